// File: rtl/sort3_pkg.sv
// sort3_pkg: shared types for the streaming three-sample sorter.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: sample width W_DEF, FSM state encoding (encoding equals samples held), sorted triple struct.
package sort3_pkg;

  parameter int W_DEF = 4;

  // Encoding is chosen so that the state value is also the fill count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } state_t;

  // Invariant over the valid entries: x >= y >= z.
  typedef struct packed {
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic [W_DEF-1:0] z;
  } triple_t;

endpackage

// File: rtl/sort3_stream_if.sv
// sort3_stream_if: sample input stream and sorted-triple output stream of sort3_stream.
// Latency: n/a (wiring only). Backpressure: valid/ready on both sides.
// Signals: in_valid/in_ready/in_data, out_valid/out_ready/out_x/out_y/out_z, fill,
//          out_dup only when SORT3_DUP_FLAG_EN is defined.
//          slave = sorter view, master = source/sink view.
interface sort3_stream_if
  import sort3_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic [W-1:0] out_z;
  logic [1:0]   fill;
`ifdef SORT3_DUP_FLAG_EN
  logic         out_dup;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, fill
`ifdef SORT3_DUP_FLAG_EN
    , output out_dup
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, fill
`ifdef SORT3_DUP_FLAG_EN
    , input out_dup
`endif
  );

endinterface

// File: rtl/sort3_insert.sv
// sort3_insert: inserts one sample into a partially filled sorted triple.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: cur_i current triple, fill_i entries already valid (0..2), v_i new sample,
//        nxt_o triple after insertion.
module sort3_insert
  import sort3_pkg::*;
(
  input  triple_t          cur_i,
  input  logic [1:0]       fill_i,
  input  logic [W_DEF-1:0] v_i,
  output triple_t          nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (fill_i)
      2'd0: begin
        // Only x becomes valid; clear the rest so no stale sample lingers.
        nxt_o.x = v_i;
        nxt_o.y = '0;
        nxt_o.z = '0;
      end
      2'd1: begin
        // y is not yet valid, so v can never be compared against it.
        if (v_i >= cur_i.x) begin
          nxt_o.x = v_i;
          nxt_o.y = cur_i.x;
        end else begin
          nxt_o.y = v_i;
        end
      end
      default: begin
        if (v_i >= cur_i.x) begin
          nxt_o.x = v_i;
          nxt_o.y = cur_i.x;
          nxt_o.z = cur_i.y;
        end else if (v_i >= cur_i.y) begin
          nxt_o.y = v_i;
          nxt_o.z = cur_i.y;
        end else begin
          nxt_o.z = v_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/sort3_stream.sv
// sort3_stream: collects three samples by insertion and offers them sorted as x>=y>=z.
// Latency: out_valid rises one cycle after the third accepted sample.
// Backpressure: in_ready = !out_valid || out_ready; a held triple stalls the input side.
// Ports: clk, rst (synchronous, active high), bus (sort3_stream_if.slave).
// Optional: SORT3_DUP_FLAG_EN adds out_dup (x==y or y==z), registered with the triple.
module sort3_stream
  import sort3_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sort3_stream_if.slave  bus
);

  state_t     state_q, state_d;
  triple_t    triple_q, triple_d;
  triple_t    ins_nxt;
  logic [1:0] ins_fill;
  logic       in_beat;
  logic       out_beat;

  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = !bus.out_valid || bus.out_ready;
  assign in_beat       = bus.in_valid && bus.in_ready;
  assign out_beat      = bus.out_valid && bus.out_ready;

  assign bus.fill  = state_q;
  assign bus.out_x = triple_q.x;
  assign bus.out_y = triple_q.y;
  assign bus.out_z = triple_q.z;

  // A sample accepted while FULL can only coincide with the out beat,
  // so it starts a fresh triple.
  assign ins_fill = (state_q == FULL) ? 2'd0 : state_q;

  sort3_insert u_insert (
    .cur_i  (triple_q),
    .fill_i (ins_fill),
    .v_i    (bus.in_data),
    .nxt_o  (ins_nxt)
  );

  always_comb begin
    state_d  = state_q;
    triple_d = triple_q;
    case (state_q)
      EMPTY: if (in_beat) state_d = ONE;
      ONE:   if (in_beat) state_d = TWO;
      TWO:   if (in_beat) state_d = FULL;
      FULL: begin
        if (out_beat) state_d = in_beat ? ONE : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (in_beat) triple_d = ins_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      triple_q <= '0;
    end else begin
      state_q  <= state_d;
      triple_q <= triple_d;
    end
  end

`ifdef SORT3_DUP_FLAG_EN
  logic dup_q, dup_d;

  // Captured only when the triple completes, so it stays aligned with x/y/z.
  always_comb begin
    dup_d = dup_q;
    if (in_beat && state_q == TWO)
      dup_d = (ins_nxt.x == ins_nxt.y) || (ins_nxt.y == ins_nxt.z);
  end

  always_ff @(posedge clk) begin
    if (rst) dup_q <= 1'b0;
    else     dup_q <= dup_d;
  end

  assign bus.out_dup = dup_q;
`endif

endmodule
